// File: rtl/rom_player_pkg.sv
// Shared types and helpers for the ROM pattern player: FSM state encoding,
// tick counter width and the last-address test.
package rom_player_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT,
    NEXT
  } state_t;

  localparam int TICK_WIDTH = 8;

  function automatic logic is_last_addr(input logic [31:0] addr, input int addr_width);
    return addr == ((32'd1 << addr_width) - 32'd1);
  endfunction

endpackage

// File: rtl/rom_pattern_player_if.sv
// Control, ROM and serial-output signals of the ROM pattern player.
// master = the environment (start/stop and ROM data), slave = the player.
interface rom_pattern_player_if #(
  parameter int Data_width = 8,
  parameter int Addr_width = 3
);
  logic                  start;
  logic                  stop;
  logic [Addr_width-1:0] addr;
  logic [Data_width-1:0] data;
  logic                  sout;
  logic                  bit_stb;
  logic                  busy;
  logic                  done;

  modport master (
    output start, stop, data,
    input  addr, sout, bit_stb, busy, done
  );

  modport slave (
    input  start, stop, data,
    output addr, sout, bit_stb, busy, done
  );
endinterface

// File: rtl/bit_timer.sv
// Bit-period timer: counts Bit_ticks cycles per serial bit and flags the first
// (bit_stb) and last (bit_end) cycle of each bit while run is high.
module bit_timer
  import rom_player_pkg::*;
#(
  parameter int Bit_ticks = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic run,
  output logic bit_stb,
  output logic bit_end
);

  logic [TICK_WIDTH-1:0] tick;
  logic                  tick_last;

  assign tick_last = tick == TICK_WIDTH'(Bit_ticks - 1);
  assign bit_stb   = run && (tick == '0);
  assign bit_end   = run && tick_last;

  // NOTE: registered state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of process evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick <= '0;
    end else if (clear) begin
      tick <= '0;
    end else if (run) begin
      tick <= tick_last ? '0 : tick + 1'b1;
    end
  end

endmodule

// File: rtl/rom_pattern_player.sv
// ROM pattern player: walks ROM addresses, captures each registered word and
// serializes it MSB first. Define ROM_PLAYER_LOOP_EN for continuous looping.
module rom_pattern_player
  import rom_player_pkg::*;
#(
  parameter int Data_width = 8,
  parameter int Addr_width = 3,
  parameter int Bit_ticks  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  rom_pattern_player_if.slave  bus
);

  localparam int Bcnt_width = $clog2(Data_width + 1);

  state_t                state, state_n;
  logic [Addr_width-1:0] addr_q, addr_n;
  logic [Data_width-1:0] shreg_q, shreg_n;
  logic [Bcnt_width-1:0] bit_cnt_q, bit_cnt_n;
  logic                  busy_q, busy_n;
  logic                  done_q, done_n;
  logic                  in_shift;
  logic                  bit_stb;
  logic                  bit_end;
`ifdef ROM_PLAYER_LOOP_EN
  logic                  stop_pend_q, stop_pend_n;
`else
  logic                  last_addr;
  assign last_addr = is_last_addr(32'(addr_q), Addr_width);
`endif

  assign in_shift = state == SHIFT;

  bit_timer #(
    .Bit_ticks (Bit_ticks)
  ) u_bit_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   (state == LOAD),
    .run     (in_shift),
    .bit_stb (bit_stb),
    .bit_end (bit_end)
  );

  // NOTE: every signal written here gets a default first; a path that leaves
  // one unassigned would infer a latch.
  always_comb begin
    state_n   = state;
    addr_n    = addr_q;
    shreg_n   = shreg_q;
    bit_cnt_n = bit_cnt_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
`ifdef ROM_PLAYER_LOOP_EN
    stop_pend_n = stop_pend_q | (busy_q & bus.stop);
`endif
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = FETCH;
          addr_n  = '0;
          busy_n  = 1'b1;
        end
      end
      FETCH: state_n = LOAD;
      LOAD: begin
        shreg_n   = bus.data;
        bit_cnt_n = '0;
        state_n   = SHIFT;
      end
      SHIFT: begin
        if (bit_end) begin
          shreg_n   = shreg_q << 1;
          bit_cnt_n = bit_cnt_q + 1'b1;
          if (bit_cnt_q == Bcnt_width'(Data_width - 1)) state_n = NEXT;
        end
      end
      NEXT: begin
`ifdef ROM_PLAYER_LOOP_EN
        // A pending stop ends the frame at whatever address just finished.
        if (stop_pend_n) begin
          state_n     = IDLE;
          busy_n      = 1'b0;
          done_n      = 1'b1;
          stop_pend_n = 1'b0;
        end else begin
          addr_n  = addr_q + 1'b1;
          state_n = FETCH;
        end
`else
        if (last_addr) begin
          state_n = IDLE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
        end else begin
          addr_n  = addr_q + 1'b1;
          state_n = FETCH;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef ROM_PLAYER_LOOP_EN
      stop_pend_q <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      shreg_q   <= shreg_n;
      bit_cnt_q <= bit_cnt_n;
      busy_q    <= busy_n;
      done_q    <= done_n;
`ifdef ROM_PLAYER_LOOP_EN
      stop_pend_q <= stop_pend_n;
`endif
    end
  end

  assign bus.addr    = addr_q;
  assign bus.sout    = in_shift & shreg_q[Data_width-1];
  assign bus.bit_stb = bit_stb;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;

endmodule

// File: tb/tb_rom_pattern_player.sv
// Self-checking bench for rom_pattern_player: two instances (Bit_ticks 4 and 1)
// against registered-ROM models and a cycle-indexed frame reference model.
module tb_rom_pattern_player;

  localparam int DW = 8;
  localparam int AW = 3;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  logic [DW-1:0] rom_a [8];
  logic [DW-1:0] rom_b [8];

  rom_pattern_player_if #(.Data_width(DW), .Addr_width(AW)) bus_a ();
  rom_pattern_player_if #(.Data_width(DW), .Addr_width(AW)) bus_b ();

  rom_pattern_player #(.Data_width(DW), .Addr_width(AW), .Bit_ticks(4)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_a)
  );

  rom_pattern_player #(.Data_width(DW), .Addr_width(AW), .Bit_ticks(1)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-output ROMs: data follows addr by one clock.
  always @(posedge clk) begin
    bus_a.data <= rom_a[bus_a.addr];
    bus_b.data <= rom_b[bus_b.addr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [6:0] get_vec(input bit sel);
    if (sel) return {bus_b.addr, bus_b.sout, bus_b.bit_stb, bus_b.busy, bus_b.done};
    return {bus_a.addr, bus_a.sout, bus_a.bit_stb, bus_a.busy, bus_a.done};
  endfunction

  task automatic set_in(input bit sel, input logic st, input logic sp);
    if (sel) begin
      bus_b.start = st;
      bus_b.stop  = sp;
    end else begin
      bus_a.start = st;
      bus_a.stop  = sp;
    end
  endtask

  // Expected {addr, sout, bit_stb, busy, done} in cycle j after the start edge.
  // The frame is a sequence of words of fixed length; end_word is the global
  // index of the last word played.
  function automatic logic [6:0] exp_vec(input bit sel, input int j, input int end_word);
    int            bt, w, k, p, q;
    logic [DW-1:0] word;
    logic          s, b;
    bt = sel ? 1 : 4;
    w  = DW * bt + 3;
    if (j <= (end_word + 1) * w) begin
      k    = (j - 1) / w;
      p    = (j - 1) % w;
      word = sel ? rom_b[k % 8] : rom_a[k % 8];
      s    = 1'b0;
      b    = 1'b0;
      if (p >= 2 && p < 2 + DW * bt) begin
        q = p - 2;
        s = word[DW - 1 - q / bt];
        b = (q % bt) == 0;
      end
      return {3'(k % 8), s, b, 1'b1, 1'b0};
    end
    return {3'(end_word % 8), 1'b0, 1'b0, 1'b0, j == (end_word + 1) * w + 1};
  endfunction

  task automatic randomize_rom(input bit sel);
    for (int i = 0; i < 8; i++) begin
      if (sel) rom_b[i] = DW'($urandom);
      else     rom_a[i] = DW'($urandom);
    end
  endtask

  // Runs one frame from an IDLE negedge and checks every cycle until a few
  // cycles past done. glitch_j re-pulses start while busy; stop is pulsed in
  // the SHIFT phase of global word stop_word.
  task automatic run_frame(input bit sel, input int stop_word, input int glitch_j,
                           input bit stop_with_start, input string name);
    int bt, w, end_word, stop_j, total;
    bt = sel ? 1 : 4;
    w  = DW * bt + 3;
`ifdef ROM_PLAYER_LOOP_EN
    end_word = stop_word;
`else
    end_word = 7;
`endif
    stop_j = stop_word * w + 3 + int'($urandom_range(0, DW * bt - 1));
    total  = (end_word + 1) * w + 3;
    set_in(sel, 1'b1, stop_with_start);
    @(negedge clk);
    for (int j = 1; j <= total; j++) begin
      check($sformatf("%s j=%0d", name, j), 32'(get_vec(sel)), 32'(exp_vec(sel, j, end_word)));
      set_in(sel, j == glitch_j, j == stop_j);
      @(negedge clk);
    end
    set_in(sel, 1'b0, 1'b0);
  endtask

  initial begin
    logic [6:0] v;
    int         stop1;
    int         stop2;
    checks = 0;
    errors = 0;
`ifdef ROM_PLAYER_LOOP_EN
    stop1 = 11;
    stop2 = int'($urandom_range(1, 9));
`else
    stop1 = 3;
    stop2 = 5;
`endif
    reset = 1'b1;
    set_in(1'b0, 1'b0, 1'b0);
    set_in(1'b1, 1'b0, 1'b0);
    randomize_rom(1'b0);
    randomize_rom(1'b1);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check($sformatf("idle_a c=%0d", i), 32'(get_vec(1'b0)), 32'h0);
    end
    check("idle_b", 32'(get_vec(1'b1)), 32'h0);

    // Single leading one in word 0, 1111_0000 in the last word.
    rom_a[0] = 8'b1000_0000;
    rom_a[7] = 8'b1111_0000;
    run_frame(1'b0, stop1, 50, 1'b0, "frame_a");

    // start and stop together in IDLE: start wins.
    randomize_rom(1'b0);
    run_frame(1'b0, stop2, 120, 1'b1, "start_stop_a");

    // Bit_ticks = 1: alternating pattern toggles every cycle.
    rom_b[0] = 8'b1010_1010;
    run_frame(1'b1, stop1, 20, 1'b0, "frame_b");

    for (int r = 0; r < 2; r++) begin
      randomize_rom(1'b0);
      randomize_rom(1'b1);
      run_frame(1'b0, stop2, 30 + r * 40, 1'b0, $sformatf("rand_a%0d", r));
      run_frame(1'b1, stop1, 15 + r * 10, 1'b0, $sformatf("rand_b%0d", r));
    end

    // Asynchronous reset in the middle of SHIFT.
    rom_a[0] = 8'hFF;
    set_in(1'b0, 1'b1, 1'b0);
    @(negedge clk);
    set_in(1'b0, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    v = get_vec(1'b0);
    check("pre_rst_sout", 32'(v[3]), 32'h1);
    check("pre_rst_busy", 32'(v[1]), 32'h1);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("rst_sout", 32'(bus_a.sout), 32'h0);
    check("rst_busy", 32'(bus_a.busy), 32'h0);
    check("rst_vec", 32'(get_vec(1'b0)), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("post_rst c=%0d", i), 32'(get_vec(1'b0)), 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rom_pattern_player.md
# rom_pattern_player

Sequencer and serializer that sits directly upstream and downstream of the registered-output ROM. It drives the ROM address, absorbs the ROM's one-cycle output-register latency, and captures each word. It then shifts the word out serially, MSB first, at a programmable bit rate. It walks addresses 0 to 2^Addr_width-1 once per start command; a compile-time option makes it loop continuously instead.

## Interface
- Data_width, 8: ROM word width; also the bits shifted per word.
- Addr_width, 3: ROM address width; the frame is 2^Addr_width words.
- Bit_ticks, 4: clock cycles each serial bit is held; legal range 1 to 255.

- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  one-cycle request to begin a frame; sampled only in IDLE.
- stop  input  1  loop-mode termination request; sampled while busy; ignored when ROM_PLAYER_LOOP_EN is undefined.
- addr  output  Addr_width  registered ROM address.
- data  input  Data_width  ROM output; valid one cycle after addr is presented.
- sout  output  1  serial data bit, MSB first.
- bit_stb  output  1  one-cycle pulse in the first cycle of each new bit on sout.
- busy  output  1  high from the cycle after start is accepted until done.
- done  output  1  one-cycle pulse when a frame completes.

## Operation
- Reset values: addr=0, sout=0, bit_stb=0, busy=0, done=0, state=IDLE, shift register=0, bit and tick counters=0.
- States:
  - IDLE: start=1 -> FETCH with addr=0 and busy=1 set at the same edge.
  - FETCH: addr is stable; the ROM registers the word. Always -> LOAD.
  - LOAD: data is captured into the shift register. Bit counter and tick counter clear. -> SHIFT.
  - SHIFT: sout equals shift register MSB. Each bit is held Bit_ticks cycles, then the register shifts left. After Data_width bits -> NEXT.
  - NEXT, one cycle:
    - If addr < 2^Addr_width-1: addr+1 -> FETCH.
    - If addr is the last address: one-shot mode -> IDLE with done=1 and busy=0. Loop mode -> addr wraps to 0 -> FETCH, unless a stop is pending.
- Outside SHIFT, sout=0. bit_stb is asserted only in SHIFT.
- In IDLE, addr holds its last value; it resets to 0 only on the next accepted start.
- start while busy: ignored, no queuing.
- start and stop in the same IDLE cycle: start accepted, stop ignored.
- Arithmetic:
  - addr increments modulo 2^Addr_width.
  - The tick counter is 8 bits; it counts 0..Bit_ticks-1.
  - The bit counter is $clog2(Data_width+1) bits wide.
- Reset mid-frame forces all reset values immediately, without waiting for clk. There is no done pulse and no partial word is emitted after reset.

## Timing
- Start accepted at edge E. FETCH is in cycle E+1, LOAD in E+2, and the first sout bit with bit_stb appears in cycle E+3.
- Per word: 1 (FETCH) + 1 (LOAD) + Data_width*Bit_ticks (SHIFT) + 1 (NEXT) cycles. With defaults this is 35 cycles per word, 280 per frame.
- done is asserted in the cycle after the last NEXT. busy falls in that same cycle.
- bit_stb period equals Bit_ticks cycles within a word. With Bit_ticks=1, bit_stb stays high for all Data_width cycles of SHIFT.

## Configuration
- ROM_PLAYER_LOOP_EN defined:
  - After the last address, the frame wraps to 0 and continues.
  - stop sets a pending flag. The current word finishes, the next NEXT goes to IDLE with done=1, and the flag clears.
- ROM_PLAYER_LOOP_EN undefined:
  - One-shot frame; stop is unused.
  - done is pulsed after the word at address 2^Addr_width-1.

## Structure
- Package rom_player_pkg holds:
  - the state enum: IDLE, FETCH, LOAD, SHIFT, NEXT;
  - the tick counter width constant (8);
  - a helper function for the last-address comparison.
- Sub-module bit_timer holds the Bit_ticks tick counter. It produces bit_stb and a bit_end strobe for the parent FSM.

## Test plan
- Reset then idle 20 cycles: all outputs 0, and addr stays 0.
- Defaults, ROM model with word 0=8'b1000_0000, start at edge E:
  - addr=0 in E+1;
  - sout=1 with bit_stb in E+3;
  - sout=0 from E+7 onward for the remaining 7 bits.
- Full one-shot frame with word 7=8'b1111_0000:
  - addr sequence 0..7 observed;
  - done pulses once, 280 cycles after start;
  - busy is low in the done cycle.
- Bit_ticks=1, word 8'b1010_1010: sout toggles every cycle, and bit_stb stays high for 8 consecutive cycles.
- start pulsed mid-frame, and start with stop in IDLE: no restart or extra frame; start is accepted in the second case.
- ROM_PLAYER_LOOP_EN, stop asserted during word 3 of the second pass:
  - word 3 completes;
  - done fires and addr stays at 3;
  - async reset asserted mid-SHIFT clears sout and busy within the same cycle.
